// File: rtl/rv_regfile_pkg.sv
// Shared register-file types and widths for the integer writeback path.
package rv_regfile_pkg;

  localparam int unsigned ADDR_WIDTH = 5;
  localparam int unsigned DATA_WIDTH = 32;

  typedef logic [ADDR_WIDTH-1:0] reg_idx_t;

  typedef struct packed {
    reg_idx_t              rd;
    logic [DATA_WIDTH-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr wins, wrapping.
module rr_arbiter #(
  parameter int unsigned N = 3,
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [N-1:0]    gnt_o,
  output logic [IdxW-1:0] gnt_idx_o
);

  logic        found;
  int unsigned idx;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    idx       = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (32'(ptr_i) + k) % N;
      if (!found && req_i[IdxW'(idx)]) begin
        gnt_o[IdxW'(idx)] = 1'b1;
        gnt_idx_o         = IdxW'(idx);
        found             = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin share of the register file write port, with a one-stage commit slot
// and a pending-write scoreboard for operand stall checks.
module regfile_wb_arbiter #(
  parameter int unsigned NUM_REQ    = 3,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_REQ-1:0]                   req_valid,
  output logic [NUM_REQ-1:0]                   req_ready,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   req_rd,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_data,
  input  logic                                 alloc_valid,
  input  logic [ADDR_WIDTH-1:0]                alloc_rd,
  input  logic [ADDR_WIDTH-1:0]                rs1,
  input  logic [ADDR_WIDTH-1:0]                rs2,
  output logic                                 rs1_busy,
  output logic                                 rs2_busy,
  output logic                                 wr_en,
  output logic [ADDR_WIDTH-1:0]                wr_rd,
  output logic [DATA_WIDTH-1:0]                wr_data,
  output logic [(2**ADDR_WIDTH)-1:0]           busy_map
);

  localparam int unsigned IdxW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned NumRegs = 2 ** ADDR_WIDTH;

  rv_regfile_pkg::wb_req_t req_arr [NUM_REQ];
  rv_regfile_pkg::wb_req_t sel;

  logic [NUM_REQ-1:0]    gnt;
  logic [IdxW-1:0]       gnt_idx;
  logic                  accept;

  logic [IdxW-1:0]       ptr_q, ptr_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_rd_q, wr_rd_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [NumRegs-1:0]    busy_q, busy_d;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_arr[i].rd   = req_rd[i];
      req_arr[i].data = req_data[i];
    end
  end

  rr_arbiter #(
    .N(NUM_REQ)
  ) u_rr_arbiter (
    .req_i    (req_valid),
    .ptr_i    (ptr_q),
    .gnt_o    (gnt),
    .gnt_idx_o(gnt_idx)
  );

  // Ready is forced low while reset is held so no requester believes it was accepted.
  assign req_ready = reset ? gnt : '0;
  assign accept    = |req_ready;
  assign sel       = req_arr[gnt_idx];

  always_comb begin
    ptr_d     = ptr_q;
    wr_en_d   = 1'b0;
    wr_rd_d   = wr_rd_q;
    wr_data_d = wr_data_q;
    if (accept) begin
      ptr_d     = (32'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
      wr_en_d   = (sel.rd != '0);
      wr_rd_d   = sel.rd;
      wr_data_d = sel.data;
    end
  end

  // Clear first, then set: a same-edge reservation belongs to a newer producer.
  always_comb begin
    busy_d = busy_q;
    if (wr_en_q) begin
      busy_d[wr_rd_q] = 1'b0;
    end
    if (alloc_valid && (alloc_rd != '0)) begin
      busy_d[alloc_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_rd_q   <= '0;
      wr_data_q <= '0;
      busy_q    <= '0;
    end else begin
      ptr_q     <= ptr_d;
      wr_en_q   <= wr_en_d;
      wr_rd_q   <= wr_rd_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_rd    = wr_rd_q;
  assign wr_data  = wr_data_q;
  assign busy_map = busy_q;
  assign rs1_busy = busy_q[rs1];
  assign rs2_busy = busy_q[rs2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench: behavioural model of arbitration, commit and scoreboard,
// directed scenarios plus randomized traffic with occasional resets.
module tb_regfile_wb_arbiter;

  logic            clk;
  logic            reset;
  logic [2:0]      req_valid;
  logic [2:0]      req_ready;
  logic [2:0][4:0] req_rd;
  logic [2:0][31:0] req_data;
  logic            alloc_valid;
  logic [4:0]      alloc_rd;
  logic [4:0]      rs1, rs2;
  logic            rs1_busy, rs2_busy;
  logic            wr_en;
  logic [4:0]      wr_rd;
  logic [31:0]     wr_data;
  logic [31:0]     busy_map;

  regfile_wb_arbiter #(
    .NUM_REQ   (3),
    .DATA_WIDTH(32),
    .ADDR_WIDTH(5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_rd     (req_rd),
    .req_data   (req_data),
    .alloc_valid(alloc_valid),
    .alloc_rd   (alloc_rd),
    .rs1        (rs1),
    .rs2        (rs2),
    .rs1_busy   (rs1_busy),
    .rs2_busy   (rs2_busy),
    .wr_en      (wr_en),
    .wr_rd      (wr_rd),
    .wr_data    (wr_data),
    .busy_map   (busy_map)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus state: what each requester is currently offering.
  bit        hold_v [3];
  bit [4:0]  hold_rd [3];
  bit [31:0] hold_data [3];
  bit        rst_v, a_v;
  bit [4:0]  a_rd, s1, s2;

  // Behavioural model.
  int        m_ptr;
  bit        m_busy [32];
  bit        m_wr_en;
  bit [4:0]  m_wr_rd;
  bit [31:0] m_wr_data;
  int        cur_g;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr     = 0;
    m_wr_en   = 0;
    m_wr_rd   = 0;
    m_wr_data = 0;
    for (int r = 0; r < 32; r++) m_busy[r] = 0;
  endtask

  function automatic int pick();
    for (int k = 0; k < 3; k++) begin
      if (hold_v[(m_ptr + k) % 3]) return (m_ptr + k) % 3;
    end
    return -1;
  endfunction

  task automatic drive();
    reset       = rst_v;
    alloc_valid = a_v;
    alloc_rd    = a_rd;
    rs1         = s1;
    rs2         = s2;
    for (int i = 0; i < 3; i++) begin
      req_valid[i] = hold_v[i];
      req_rd[i]    = hold_rd[i];
      req_data[i]  = hold_data[i];
    end
  endtask

  task automatic compare();
    logic [2:0]  exp_rdy;
    logic [31:0] exp_map;
    if (!rst_v) model_reset();
    cur_g   = rst_v ? pick() : -1;
    exp_rdy = '0;
    if (cur_g >= 0) exp_rdy[cur_g] = 1'b1;
    for (int r = 0; r < 32; r++) exp_map[r] = m_busy[r];
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    chk("wr_en", 64'(wr_en), 64'(m_wr_en));
    chk("wr_rd", 64'(wr_rd), 64'(m_wr_rd));
    chk("wr_data", 64'(wr_data), 64'(m_wr_data));
    chk("busy_map", 64'(busy_map), 64'(exp_map));
    chk("rs1_busy", 64'(rs1_busy), 64'(m_busy[s1]));
    chk("rs2_busy", 64'(rs2_busy), 64'(m_busy[s2]));
  endtask

  task automatic tick();
    @(negedge clk);
    drive();
    #1;
    compare();
  endtask

  // mode 0: winner goes idle; 1: random refill; 2: winner stays valid with a new nonzero rd.
  task automatic update(input int mode);
    if (!rst_v) return;
    if (m_wr_en) m_busy[m_wr_rd] = 0;
    if (a_v && a_rd != 0) m_busy[a_rd] = 1;
    if (cur_g >= 0) begin
      m_wr_en   = (hold_rd[cur_g] != 0);
      m_wr_rd   = hold_rd[cur_g];
      m_wr_data = hold_data[cur_g];
      m_ptr     = (cur_g + 1) % 3;
      case (mode)
        0: hold_v[cur_g] = 0;
        1: hold_v[cur_g] = 0;
        default: begin
          hold_v[cur_g]    = 1;
          hold_rd[cur_g]   = 5'($urandom_range(1, 31));
          hold_data[cur_g] = $urandom;
        end
      endcase
    end else begin
      m_wr_en = 0;
    end
    if (mode == 1) begin
      for (int i = 0; i < 3; i++) begin
        if (!hold_v[i] && $urandom_range(0, 1) == 1) begin
          hold_v[i]    = 1;
          hold_rd[i]   = 5'($urandom_range(0, 31));
          hold_data[i] = $urandom;
        end
      end
    end
  endtask

  int grants [6];
  int waited;
  bit seen;
  int rst_cnt;

  initial begin
    rst_v = 0; a_v = 0; a_rd = 0; s1 = 0; s2 = 0;
    for (int i = 0; i < 3; i++) begin
      hold_v[i] = 0; hold_rd[i] = 0; hold_data[i] = 0;
    end
    model_reset();
    drive();
    tick(); update(0);
    tick(); update(0);
    rst_v = 1;

    // Traffic with reservations, then reset mid-traffic.
    for (int i = 0; i < 3; i++) begin
      hold_v[i] = 1; hold_rd[i] = 5'(i + 10); hold_data[i] = 32'hA000 + i;
    end
    a_v = 1; a_rd = 5'd3;
    tick(); update(2);
    a_rd = 5'd4;
    tick(); update(2);
    a_v = 0;
    rst_v = 0;
    tick();
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_busy_map", 64'(busy_map), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    update(2);
    tick(); update(2);
    rst_v = 1;

    // Fairness from ptr=0; the first accept after reset goes to requester 0.
    for (int k = 0; k < 6; k++) begin
      tick();
      grants[k] = cur_g;
      if (k == 0) chk("post_rst_first_grant", 64'(req_ready), 64'b001);
      if (k > 0) chk("fair_wr_en", 64'(wr_en), 64'd1);
      update(2);
    end
    for (int k = 0; k < 6; k++) chk("fair_order", 64'(grants[k]), 64'(k % 3));
    for (int i = 0; i < 3; i++) hold_v[i] = 0;
    tick();
    chk("fair_wr_en_last", 64'(wr_en), 64'd1);
    update(0);

    // Single requester.
    hold_v[1] = 1; hold_rd[1] = 5'd7; hold_data[1] = 32'hDEADBEEF;
    tick();
    chk("single_ready", 64'(req_ready), 64'b010);
    update(0);
    tick();
    chk("single_wr_en", 64'(wr_en), 64'd1);
    chk("single_wr_rd", 64'(wr_rd), 64'd7);
    chk("single_wr_data", 64'(wr_data), 64'hDEADBEEF);
    update(0);

    // Write to x0 is accepted and dropped.
    hold_v[0] = 1; hold_rd[0] = 5'd0; hold_data[0] = 32'h55;
    tick();
    chk("x0_ready", 64'(req_ready), 64'b001);
    update(0);
    tick();
    chk("x0_wr_en", 64'(wr_en), 64'd0);
    chk("x0_busy0", 64'(busy_map[0]), 64'd0);
    update(0);

    // Scoreboard set and clear.
    a_v = 1; a_rd = 5'd5; s1 = 5'd5;
    tick(); update(0);
    a_v = 0;
    hold_v[1] = 1; hold_rd[1] = 5'd5; hold_data[1] = 32'h1234;
    tick();
    chk("sb_busy_after_alloc", 64'(rs1_busy), 64'd1);
    update(0);
    tick();
    chk("sb_commit_wr_en", 64'(wr_en), 64'd1);
    chk("sb_busy_during_wr", 64'(rs1_busy), 64'd1);
    update(0);
    tick();
    chk("sb_busy_cleared", 64'(rs1_busy), 64'd0);
    update(0);

    // Same-edge set and clear of x5: set wins.
    a_v = 1; a_rd = 5'd5;
    tick(); update(0);
    a_v = 0;
    hold_v[2] = 1; hold_rd[2] = 5'd5; hold_data[2] = 32'h77;
    tick(); update(0);
    a_v = 1; a_rd = 5'd5;
    tick();
    chk("sb_collide_wr_en", 64'(wr_en), 64'd1);
    update(0);
    a_v = 0;
    tick();
    chk("sb_collide_busy5", 64'(busy_map[5]), 64'd1);
    update(0);

    // Starvation: requester 2 held while requester 0 toggles.
    hold_v[2] = 1; hold_rd[2] = 5'd9; hold_data[2] = 32'h99;
    seen = 0; waited = 0;
    for (int n = 0; n < 6 && !seen; n++) begin
      hold_v[0] = (n % 2 == 0);
      hold_rd[0] = 5'd1; hold_data[0] = 32'h11;
      tick();
      waited++;
      if (req_ready[2]) seen = 1;
      update(0);
    end
    chk("starve_grant_within_n", 64'(seen && waited <= 3), 64'd1);
    hold_v[0] = 0; hold_v[2] = 0;

    // Randomized traffic with occasional resets.
    rst_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      if (rst_cnt > 0) begin
        rst_cnt--;
        rst_v = (rst_cnt == 0);
      end else if ($urandom_range(0, 299) == 0) begin
        rst_v = 0;
        rst_cnt = 2;
      end
      a_v  = ($urandom_range(0, 2) == 0);
      a_rd = 5'($urandom_range(0, 31));
      s1   = 5'($urandom_range(0, 31));
      s2   = 5'($urandom_range(0, 31));
      tick();
      update(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the single write port of the 32-entry integer register file among NUM_REQ writeback requesters: ALU, load unit and multiply/divide unit. It uses round-robin arbitration with a valid/ready handshake. The block registers the winning write into a one-stage commit slot that drives the register file write port. It also keeps a pending-write scoreboard so the issue logic can stall on RS/RT operands that are not yet written.

## Interface
Parameters:
- NUM_REQ, 3, number of writeback requesters (index 0 = ALU, 1 = load, 2 = mul/div)
- DATA_WIDTH, 32, write data width
- ADDR_WIDTH, 5, register index width (32 registers)

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-low
- req_valid  in  NUM_REQ  requester i holds a write
- req_ready  out  NUM_REQ  requester i accepted this cycle
- req_rd  in  NUM_REQ x ADDR_WIDTH  destination register per requester
- req_data  in  NUM_REQ x DATA_WIDTH  write data per requester
- alloc_valid  in  1  issue stage reserves a destination
- alloc_rd  in  ADDR_WIDTH  register being reserved
- rs1, rs2  in  ADDR_WIDTH  operand indices to check
- rs1_busy, rs2_busy  out  1  operand has a pending write
- wr_en  out  1  register file write enable
- wr_rd  out  ADDR_WIDTH  register file write index
- wr_data  out  DATA_WIDTH  register file write data
- busy_map  out  2^ADDR_WIDTH  scoreboard bitmap

## Operation
- Arbitration:
  - Round-robin pointer ptr, range 0..NUM_REQ-1.
  - The grant goes to the first i with req_valid[i], searching from ptr upward and wrapping.
  - At most one grant per cycle.
  - req_ready = one-hot grant vector, combinational from req_valid and ptr. No requests means all zeros.
- Handshake:
  - A transfer occurs when req_valid[i] and req_ready[i] are both high.
  - A requester holds valid, rd and data stable until it is accepted. A non-granted requester sees ready low and retries.
- Pointer update: on an accept from i, ptr <= (i+1) mod NUM_REQ. It is unchanged when idle.
- Commit stage:
  - On an accept, wr_rd <= req_rd[i] and wr_data <= req_data[i].
  - wr_en <= 1 only if req_rd[i] != 0. A write to x0 is accepted but discarded.
  - With no accept, wr_en <= 0; wr_rd and wr_data hold their values.
- Scoreboard, busy_map:
  - Set: alloc_valid with alloc_rd != 0 sets bit alloc_rd.
  - Clear: the edge on which wr_en=1 clears bit wr_rd.
  - Same register set and cleared on the same edge: the set wins, because the bit now tracks the newer producer.
  - busy_map[0] is constant 0.
  - A write to a non-busy register is legal and simply commits.
- rs1_busy = busy_map[rs1] and rs2_busy = busy_map[rs2], both combinational.
- Bypassing: none. The register file read of the committed value is valid the cycle after wr_en.

## Timing
- Reset values: ptr=0, wr_en=0, wr_rd=0, wr_data=0, busy_map=0, req_ready=0. Reset is asynchronous and takes effect immediately.
- Reset mid-operation drops the in-flight commit and all reservations.
- Grant latency: 0 cycles. Ready is asserted in the same cycle as valid when the requester wins.
- Commit latency: the accept at edge N gives wr_en high during cycle N+1. The register file write happens at edge N+1.
- Throughput: one accepted write per cycle, back-to-back.
- Fairness: with all NUM_REQ requesters continuously valid, each is granted exactly once every NUM_REQ cycles.
- Reservation visibility: alloc at edge N makes rsX_busy high from cycle N+1. The commit at edge M makes it low from cycle M+1.

## Structure
- Shared package rv_regfile_pkg:
  - ADDR_WIDTH and DATA_WIDTH constants.
  - Typedef wb_req_t {rd, data}.
  - Typedef reg_idx_t.
- The requester port arrays use wb_req_t.
- Sub-module rr_arbiter #(N):
  - Inputs req[N], ptr; output one-hot gnt[N] and encoded gnt_idx.
  - It is combinational. The pointer register lives in the parent.
- The commit stage and the scoreboard live in regfile_wb_arbiter.

## Test plan
- Reset mid-traffic, with reset low for 2 cycles: wr_en=0, busy_map=0 and req_ready=0 immediately. The first accept after release goes to requester 0.
- Single requester: req_valid=3'b010, rd=7, data=0xDEADBEEF gives req_ready=3'b010 the same cycle. The next cycle gives wr_en=1, wr_rd=7, wr_data=0xDEADBEEF.
- All three valid for 6 cycles from ptr=0: grant order is 0,1,2,0,1,2. wr_en is high for 6 consecutive cycles.
- Write to x0: rd=0, data=0x55 is accepted (ready=1). The next cycle wr_en=0 and busy_map[0] stays 0.
- Scoreboard:
  - alloc rd=5, then rs1=5 gives rs1_busy=1 from the next cycle.
  - A load accepted with rd=5 gives rs1_busy=0 the cycle after wr_en.
  - Simultaneous alloc rd=5 and commit rd=5 leaves busy_map[5]=1.
- Starvation check: requester 2 held valid while requester 0 toggles valid every cycle. Requester 2 is granted within NUM_REQ cycles.
